// File: rtl/spot_metering.sv
// Spot metering tap on the debayered RGB stream: per-channel window means and luma at frame end.
// Optional per-channel window peaks are built when SPOT_METERING_PEAK_EN is defined.
module spot_metering #(
    parameter int X_RESOLUTION       = 640,
    parameter int Y_RESOLUTION       = 400,
    parameter int WINDOW_X_START     = 192,
    parameter int WINDOW_Y_START     = 136,
    parameter int WINDOW_WIDTH_LOG2  = 8,
    parameter int WINDOW_HEIGHT_LOG2 = 7
) (
    input  logic       pixel_clock_in,
    input  logic       reset_n_in,
    input  logic [9:0] pixel_red_data_in,
    input  logic [9:0] pixel_green_data_in,
    input  logic [9:0] pixel_blue_data_in,
    input  logic       line_valid_in,
    input  logic       frame_valid_in,
    output logic [9:0] red_average_out,
    output logic [9:0] green_average_out,
    output logic [9:0] blue_average_out,
    output logic [9:0] luma_average_out,
    output logic       metering_valid_out,
    output logic       frame_incomplete_out,
    output logic [9:0] red_peak_out,
    output logic [9:0] green_peak_out,
    output logic [9:0] blue_peak_out
);

    localparam int WH    = WINDOW_WIDTH_LOG2 + WINDOW_HEIGHT_LOG2;
    localparam int ACC_W = 10 + WH;
    localparam int CNT_W = WH + 1;

    localparam logic [12:0] X_LO = 13'(WINDOW_X_START);
    localparam logic [12:0] X_HI = 13'(WINDOW_X_START + (1 << WINDOW_WIDTH_LOG2));
    localparam logic [12:0] Y_LO = 13'(WINDOW_Y_START);
    localparam logic [12:0] Y_HI = 13'(WINDOW_Y_START + (1 << WINDOW_HEIGHT_LOG2));
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(1 << WH);

    typedef enum logic [1:0] {
        WAIT_IDLE  = 2'd0,
        IDLE       = 2'd1,
        ACCUMULATE = 2'd2,
        FINALISE   = 2'd3
    } state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    state_t             state_q, state_d;
    logic [11:0]        x_count_q, x_count_d;
    logic [11:0]        y_count_q, y_count_d;
    logic               lv_prev_q, lv_prev_d;
    logic [ACC_W-1:0]   red_sum_q, red_sum_d;
    logic [ACC_W-1:0]   green_sum_q, green_sum_d;
    logic [ACC_W-1:0]   blue_sum_q, blue_sum_d;
    logic [CNT_W-1:0]   window_count_q, window_count_d;
    logic [9:0]         red_avg_q, red_avg_d;
    logic [9:0]         green_avg_q, green_avg_d;
    logic [9:0]         blue_avg_q, blue_avg_d;
    logic [9:0]         red_out_q, red_out_d;
    logic [9:0]         green_out_q, green_out_d;
    logic [9:0]         blue_out_q, blue_out_d;
    logic [9:0]         luma_out_q, luma_out_d;
    logic               valid_q, valid_d;
    logic               incomplete_q, incomplete_d;

    logic               frame_start_s;
    logic               counting_s;
    logic               in_window_s;
    logic               complete_s;
    logic [11:0]        x_base_s, y_base_s;
    logic [ACC_W-1:0]   red_base_s, green_base_s, blue_base_s;
    logic [CNT_W-1:0]   count_base_s;
    logic [13:0]        luma_s;

    // Frame start folds the counter clear into the first counted cycle so a pixel arriving then is kept.
    always_comb begin
        frame_start_s = (state_q == IDLE) && frame_valid_in;
        counting_s    = (state_q == ACCUMULATE) || frame_start_s;
        complete_s    = (window_count_q == FULL_COUNT);
        x_base_s      = frame_start_s ? 12'd0 : x_count_q;
        y_base_s      = frame_start_s ? 12'd0 : y_count_q;
        red_base_s    = frame_start_s ? {ACC_W{1'b0}} : red_sum_q;
        green_base_s  = frame_start_s ? {ACC_W{1'b0}} : green_sum_q;
        blue_base_s   = frame_start_s ? {ACC_W{1'b0}} : blue_sum_q;
        count_base_s  = frame_start_s ? {CNT_W{1'b0}} : window_count_q;
        in_window_s   = counting_s && line_valid_in &&
                        ({1'b0, x_base_s} >= X_LO) && ({1'b0, x_base_s} < X_HI) &&
                        ({1'b0, y_base_s} >= Y_LO) && ({1'b0, y_base_s} < Y_HI);
        luma_s        = {3'b000, red_avg_q, 1'b0} + (14'(green_avg_q) * 14'd5) +
                        {4'b0000, blue_avg_q};
    end

    // Next-state computation for the FSM, counters, accumulators and published results.
    always_comb begin
        state_d        = state_q;
        x_count_d      = x_count_q;
        y_count_d      = y_count_q;
        lv_prev_d      = lv_prev_q;
        red_sum_d      = red_sum_q;
        green_sum_d    = green_sum_q;
        blue_sum_d     = blue_sum_q;
        window_count_d = window_count_q;
        red_avg_d      = red_avg_q;
        green_avg_d    = green_avg_q;
        blue_avg_d     = blue_avg_q;
        red_out_d      = red_out_q;
        green_out_d    = green_out_q;
        blue_out_d     = blue_out_q;
        luma_out_d     = luma_out_q;
        valid_d        = 1'b0;
        incomplete_d   = 1'b0;

        if (counting_s) begin
            lv_prev_d = line_valid_in;
            if (line_valid_in) begin
                x_count_d = sat_inc(x_base_s);
                y_count_d = y_base_s;
            end else if (lv_prev_q && (state_q == ACCUMULATE)) begin
                x_count_d = 12'd0;
                y_count_d = sat_inc(y_base_s);
            end else begin
                x_count_d = x_base_s;
                y_count_d = y_base_s;
            end
            if (in_window_s) begin
                red_sum_d      = red_base_s + ACC_W'(pixel_red_data_in);
                green_sum_d    = green_base_s + ACC_W'(pixel_green_data_in);
                blue_sum_d     = blue_base_s + ACC_W'(pixel_blue_data_in);
                window_count_d = count_base_s + CNT_W'(1);
            end else begin
                red_sum_d      = red_base_s;
                green_sum_d    = green_base_s;
                blue_sum_d     = blue_base_s;
                window_count_d = count_base_s;
            end
        end else begin
            lv_prev_d = 1'b0;
        end

        case (state_q)
            WAIT_IDLE: begin
                if (!frame_valid_in) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            IDLE: begin
                if (frame_valid_in) begin
                    state_d = ACCUMULATE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUMULATE: begin
                if (!frame_valid_in) begin
                    state_d = FINALISE;
                    if (complete_s) begin
                        red_avg_d   = red_sum_q[ACC_W-1:WH];
                        green_avg_d = green_sum_q[ACC_W-1:WH];
                        blue_avg_d  = blue_sum_q[ACC_W-1:WH];
                    end else begin
                        red_avg_d   = red_avg_q;
                    end
                end else begin
                    state_d = ACCUMULATE;
                end
            end
            FINALISE: begin
                state_d = IDLE;
                if (complete_s) begin
                    red_out_d   = red_avg_q;
                    green_out_d = green_avg_q;
                    blue_out_d  = blue_avg_q;
                    luma_out_d  = luma_s[12:3];
                    valid_d     = 1'b1;
                end else begin
                    incomplete_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q        <= WAIT_IDLE;
            x_count_q      <= 12'd0;
            y_count_q      <= 12'd0;
            lv_prev_q      <= 1'b0;
            red_sum_q      <= {ACC_W{1'b0}};
            green_sum_q    <= {ACC_W{1'b0}};
            blue_sum_q     <= {ACC_W{1'b0}};
            window_count_q <= {CNT_W{1'b0}};
            red_avg_q      <= 10'd0;
            green_avg_q    <= 10'd0;
            blue_avg_q     <= 10'd0;
            red_out_q      <= 10'd0;
            green_out_q    <= 10'd0;
            blue_out_q     <= 10'd0;
            luma_out_q     <= 10'd0;
            valid_q        <= 1'b0;
            incomplete_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_count_q      <= x_count_d;
            y_count_q      <= y_count_d;
            lv_prev_q      <= lv_prev_d;
            red_sum_q      <= red_sum_d;
            green_sum_q    <= green_sum_d;
            blue_sum_q     <= blue_sum_d;
            window_count_q <= window_count_d;
            red_avg_q      <= red_avg_d;
            green_avg_q    <= green_avg_d;
            blue_avg_q     <= blue_avg_d;
            red_out_q      <= red_out_d;
            green_out_q    <= green_out_d;
            blue_out_q     <= blue_out_d;
            luma_out_q     <= luma_out_d;
            valid_q        <= valid_d;
            incomplete_q   <= incomplete_d;
        end
    end

    assign red_average_out      = red_out_q;
    assign green_average_out    = green_out_q;
    assign blue_average_out     = blue_out_q;
    assign luma_average_out     = luma_out_q;
    assign metering_valid_out   = valid_q;
    assign frame_incomplete_out = incomplete_q;

`ifdef SPOT_METERING_PEAK_EN
    logic [9:0] red_max_q, red_max_d;
    logic [9:0] green_max_q, green_max_d;
    logic [9:0] blue_max_q, blue_max_d;
    logic [9:0] red_pk_q, red_pk_d;
    logic [9:0] green_pk_q, green_pk_d;
    logic [9:0] blue_pk_q, blue_pk_d;
    logic [9:0] red_mbase_s, green_mbase_s, blue_mbase_s;

    // Running window maxima, published under the same complete-window rule as the means.
    always_comb begin
        red_mbase_s   = frame_start_s ? 10'd0 : red_max_q;
        green_mbase_s = frame_start_s ? 10'd0 : green_max_q;
        blue_mbase_s  = frame_start_s ? 10'd0 : blue_max_q;
        red_max_d     = red_max_q;
        green_max_d   = green_max_q;
        blue_max_d    = blue_max_q;
        red_pk_d      = red_pk_q;
        green_pk_d    = green_pk_q;
        blue_pk_d     = blue_pk_q;
        if (counting_s) begin
            if (in_window_s) begin
                red_max_d   = (pixel_red_data_in   > red_mbase_s)   ? pixel_red_data_in   : red_mbase_s;
                green_max_d = (pixel_green_data_in > green_mbase_s) ? pixel_green_data_in : green_mbase_s;
                blue_max_d  = (pixel_blue_data_in  > blue_mbase_s)  ? pixel_blue_data_in  : blue_mbase_s;
            end else begin
                red_max_d   = red_mbase_s;
                green_max_d = green_mbase_s;
                blue_max_d  = blue_mbase_s;
            end
        end else begin
            red_max_d = red_max_q;
        end
        if ((state_q == FINALISE) && complete_s) begin
            red_pk_d   = red_max_q;
            green_pk_d = green_max_q;
            blue_pk_d  = blue_max_q;
        end else begin
            red_pk_d   = red_pk_q;
        end
    end

    // Peak registers.
    always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            red_max_q   <= 10'd0;
            green_max_q <= 10'd0;
            blue_max_q  <= 10'd0;
            red_pk_q    <= 10'd0;
            green_pk_q  <= 10'd0;
            blue_pk_q   <= 10'd0;
        end else begin
            red_max_q   <= red_max_d;
            green_max_q <= green_max_d;
            blue_max_q  <= blue_max_d;
            red_pk_q    <= red_pk_d;
            green_pk_q  <= green_pk_d;
            blue_pk_q   <= blue_pk_d;
        end
    end

    assign red_peak_out   = red_pk_q;
    assign green_peak_out = green_pk_q;
    assign blue_peak_out  = blue_pk_q;
`else
    assign red_peak_out   = 10'd0;
    assign green_peak_out = 10'd0;
    assign blue_peak_out  = 10'd0;
`endif

endmodule

// File: tb/tb_spot_metering.sv
// Directed bench for spot_metering with a 4x2 window inside an 8x6 frame.
module tb_spot_metering;

`ifdef SPOT_METERING_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [9:0] r_in, g_in, b_in;
    logic       lv, fv;
    logic [9:0] r_avg, g_avg, b_avg, l_avg;
    logic       valid, incomplete;
    logic [9:0] r_pk, g_pk, b_pk;

    int n_checks = 0;
    int n_errors = 0;

    spot_metering #(
        .X_RESOLUTION(8), .Y_RESOLUTION(6),
        .WINDOW_X_START(2), .WINDOW_Y_START(1),
        .WINDOW_WIDTH_LOG2(2), .WINDOW_HEIGHT_LOG2(1)
    ) dut (
        .pixel_clock_in(clk), .reset_n_in(rst_n),
        .pixel_red_data_in(r_in), .pixel_green_data_in(g_in), .pixel_blue_data_in(b_in),
        .line_valid_in(lv), .frame_valid_in(fv),
        .red_average_out(r_avg), .green_average_out(g_avg), .blue_average_out(b_avg),
        .luma_average_out(l_avg), .metering_valid_out(valid),
        .frame_incomplete_out(incomplete),
        .red_peak_out(r_pk), .green_peak_out(g_pk), .blue_peak_out(b_pk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pixel_value(input int x, input int y, input int mode,
                               output logic [9:0] r, output logic [9:0] g, output logic [9:0] b);
        r = 10'd0; g = 10'd0; b = 10'd0;
        case (mode)
            0: begin r = 10'd100; g = 10'd200; b = 10'd300; end
            1: begin r = 10'(16 * x); end
            2: begin r = 10'd100; g = 10'd100; b = 10'd100; end
            3: begin r = 10'd10; b = 10'd10;
                     g = (((x == 3) && (y == 2)) || ((x == 0) && (y == 0))) ? 10'd1023 : 10'd10; end
            4: begin r = 10'd10; b = 10'd10;
                     g = ((x == 0) && (y == 0)) ? 10'd1023 : 10'd10; end
            default: begin r = 10'd0; end
        endcase
    endtask

    task automatic drive_lines(input int y0, input int n, input int mode);
        for (int y = y0; y < y0 + n; y++) begin
            for (int x = 0; x < 8; x++) begin
                @(negedge clk);
                lv = 1'b1;
                pixel_value(x, y, mode, r_in, g_in, b_in);
            end
            @(negedge clk);
            lv = 1'b0; r_in = 10'd0; g_in = 10'd0; b_in = 10'd0;
            @(negedge clk);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        fv = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_check(input string name, input logic exp_valid, input logic exp_inc,
                             input int er, input int eg, input int eb, input int el,
                             input int pr, input int pg, input int pb);
        logic [29:0] exp_pk;
        exp_pk = PEAK_EN ? {10'(pr), 10'(pg), 10'(pb)} : 30'd0;
        @(negedge clk);
        fv = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({valid, incomplete} !== 2'b00) begin
            n_errors++;
            $display("FAIL %s early_pulse: got valid=%b inc=%b expected 0 0", name, valid, incomplete);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== exp_valid) begin
            n_errors++;
            $display("FAIL %s valid: got %b expected %b", name, valid, exp_valid);
        end
        n_checks++;
        if (incomplete !== exp_inc) begin
            n_errors++;
            $display("FAIL %s incomplete: got %b expected %b", name, incomplete, exp_inc);
        end
        n_checks++;
        if ({r_avg, g_avg, b_avg} !== {10'(er), 10'(eg), 10'(eb)}) begin
            n_errors++;
            $display("FAIL %s rgb_avg: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     name, r_avg, g_avg, b_avg, er, eg, eb);
        end
        n_checks++;
        if (l_avg !== 10'(el)) begin
            n_errors++;
            $display("FAIL %s luma: got %0d expected %0d", name, l_avg, el);
        end
        n_checks++;
        if ({r_pk, g_pk, b_pk} !== exp_pk) begin
            n_errors++;
            $display("FAIL %s peaks: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     name, r_pk, g_pk, b_pk, exp_pk[29:20], exp_pk[19:10], exp_pk[9:0]);
        end
        @(negedge clk);
        n_checks++;
        if ({valid, incomplete} !== 2'b00) begin
            n_errors++;
            $display("FAIL %s pulse_width: got valid=%b inc=%b expected 0 0", name, valid, incomplete);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fv = 1'b0; lv = 1'b0;
        r_in = 10'd0; g_in = 10'd0; b_in = 10'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({r_avg, g_avg, b_avg, l_avg, valid, incomplete, r_pk, g_pk, b_pk} !== 72'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got nonzero outputs expected all 0");
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_constant();
        start_frame();
        drive_lines(0, 6, 0);
        end_check("constant", 1'b1, 1'b0, 100, 200, 300, 187, 100, 200, 300);
    endtask

    task automatic test_ramp();
        start_frame();
        drive_lines(0, 6, 1);
        end_check("ramp", 1'b1, 1'b0, 56, 0, 0, 14, 80, 0, 0);
    endtask

    task automatic test_incomplete();
        start_frame();
        drive_lines(0, 6, 2);
        end_check("incomplete_f1", 1'b1, 1'b0, 100, 100, 100, 100, 100, 100, 100);
        start_frame();
        drive_lines(0, 2, 0);
        end_check("incomplete_f2", 1'b0, 1'b1, 100, 100, 100, 100, 100, 100, 100);
    endtask

    task automatic test_back_to_back();
        start_frame();
        drive_lines(0, 6, 0);
        @(negedge clk);
        fv = 1'b0;
        @(negedge clk);
        fv = 1'b1;
        @(negedge clk);
        n_checks++;
        if ((valid !== 1'b1) || (r_avg !== 10'd100)) begin
            n_errors++;
            $display("FAIL b2b_first: got valid=%b red=%0d expected 1 100", valid, r_avg);
        end
        drive_lines(0, 6, 1);
        end_check("b2b_second", 1'b1, 1'b0, 56, 0, 0, 14, 80, 0, 0);
    endtask

    task automatic test_reset_during_frame();
        @(negedge clk);
        rst_n = 1'b0;
        fv = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_lines(0, 6, 0);
        end_check("rst_in_frame", 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        start_frame();
        drive_lines(0, 6, 0);
        end_check("after_rst_in_frame", 1'b1, 1'b0, 100, 200, 300, 187, 100, 200, 300);
    endtask

    task automatic test_reset_mid_frame();
        start_frame();
        drive_lines(0, 2, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({r_avg, g_avg, b_avg, l_avg, r_pk, g_pk, b_pk} !== 70'd0) begin
            n_errors++;
            $display("FAIL mid_rst_clear: got red=%0d luma=%0d expected 0 0", r_avg, l_avg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_lines(2, 4, 1);
        end_check("mid_rst_frame", 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        start_frame();
        drive_lines(0, 6, 1);
        end_check("after_mid_rst", 1'b1, 1'b0, 56, 0, 0, 14, 80, 0, 0);
    endtask

    task automatic test_peak();
        start_frame();
        drive_lines(0, 6, 3);
        end_check("peak_in_window", 1'b1, 1'b0, 10, 136, 10, 88, 10, 1023, 10);
        start_frame();
        drive_lines(0, 6, 4);
        end_check("peak_outside", 1'b1, 1'b0, 10, 10, 10, 10, 10, 10, 10);
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_incomplete();
        test_back_to_back();
        test_reset_during_frame();
        test_reset_mid_frame();
        test_peak();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
